// File: rtl/vec_mul_seq_pkg.sv
// Shared types for the vector multiply sequencer: FSM states, latency bound, product tag.
package vec_mul_seq_pkg;
    localparam int MUL_LAT_MAX = 8;
    localparam int TAG_IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/vec_mul_seq_lat_pipe.sv
// mul_lat_pipe: valid/index tag shift register that tracks products through the multiplier.
// DEPTH=0 is a pass-through; any_valid flags tags that will still be in flight after this edge.
module mul_lat_pipe
    import vec_mul_seq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             any_valid
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
            assign any_valid = 1'b0;
        end else begin : g_pipe
            tag_t stage_q [DEPTH];
            tag_t stage_d [DEPTH];
            logic pending;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign stage_d[gi] = '{valid: in_valid, idx: TAG_IDX_W'(in_idx)};
                end else begin : g_body
                    assign stage_d[gi] = stage_q[gi-1];
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
                end
            end

            // The last stage is consumed this cycle, so it does not hold DRAIN open.
            always_comb begin
                pending = 1'b0;
                for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage_q[i].valid;
            end

            assign out_valid = stage_q[DEPTH-1].valid;
            assign out_idx   = stage_q[DEPTH-1].idx[IDX_W-1:0];
            assign any_valid = pending;
        end
    endgenerate
endmodule

// File: rtl/vec_mul_sequencer.sv
// Time-multiplexes one shared element multiplier across a vector multiply request.
// Optional VEC_MUL_SEQ_ACCUM_EN adds resp_sum, the wrap-around sum of all captured products.
module vec_mul_sequencer
    import vec_mul_seq_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int NUM_ELEMS = 8,
    parameter  int MUL_LAT   = 2,
    localparam int IDX_W     = $clog2(NUM_ELEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IDX_W:0]       req_vl,
    input  logic [WIDTH-1:0]     req_a [0:NUM_ELEMS-1],
    input  logic [WIDTH-1:0]     req_b [0:NUM_ELEMS-1],
    output logic                 mul_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   resp_p [0:NUM_ELEMS-1],
    output logic                 busy
`ifdef VEC_MUL_SEQ_ACCUM_EN
    ,
    output logic [2*WIDTH-1:0]   resp_sum
`endif
);
    localparam int             PW   = 2 * WIDTH;
    localparam logic [IDX_W:0] NE_V = (IDX_W + 1)'(NUM_ELEMS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
    logic [IDX_W:0]   vl_q, vl_d, req_vl_eff;
    logic [WIDTH-1:0] a_q [NUM_ELEMS];
    logic [WIDTH-1:0] a_d [NUM_ELEMS];
    logic [WIDTH-1:0] b_q [NUM_ELEMS];
    logic [WIDTH-1:0] b_d [NUM_ELEMS];
    logic [PW-1:0]    resp_p_q [NUM_ELEMS];
    logic [PW-1:0]    resp_p_d [NUM_ELEMS];
    logic             req_ready_q, req_ready_d;
    logic             mul_valid_q, mul_valid_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    sum_q, sum_d;
    logic             cap_valid, pipe_pending, last_issue;
    logic [IDX_W-1:0] cap_idx;

    assign req_vl_eff = (req_vl > NE_V) ? NE_V : req_vl;
    assign last_issue = ({1'b0, idx_q} == (vl_q - 1'b1));
    assign idx_nxt    = idx_q + 1'b1;

    mul_lat_pipe #(
        .DEPTH (MUL_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk       (clk),
        .srst      (rst),
        .in_valid  (mul_valid_q),
        .in_idx    (idx_q),
        .out_valid (cap_valid),
        .out_idx   (cap_idx),
        .any_valid (pipe_pending)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        vl_d         = vl_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_p_d     = resp_p_q;
        req_ready_d  = req_ready_q;
        mul_valid_d  = 1'b0;
        mul_a_d      = '0;
        mul_b_d      = '0;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        sum_d        = sum_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d         = req_a;
                    b_d         = req_b;
                    vl_d        = req_vl_eff;
                    idx_d       = '0;
                    sum_d       = '0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    for (int i = 0; i < NUM_ELEMS; i++) resp_p_d[i] = '0;
                    if (req_vl_eff != '0) begin
                        state_d     = ISSUE;
                        mul_valid_d = 1'b1;
                        mul_a_d     = req_a[0];
                        mul_b_d     = req_b[0];
                    end else begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_d      = (MUL_LAT > 0) ? DRAIN : DONE;
                    resp_valid_d = (MUL_LAT == 0);
                end else begin
                    idx_d       = idx_nxt;
                    mul_valid_d = 1'b1;
                    mul_a_d     = a_q[idx_nxt];
                    mul_b_d     = b_q[idx_nxt];
                end
            end
            DRAIN: begin
                if (!pipe_pending) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Products return tagged with their element index; capture lands in the matching slot.
        if (cap_valid) begin
            resp_p_d[cap_idx] = mul_p;
            sum_d             = sum_d + mul_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            vl_q         <= '0;
            req_ready_q  <= 1'b1;
            mul_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            sum_q        <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                resp_p_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vl_q         <= vl_d;
            req_ready_q  <= req_ready_d;
            mul_valid_q  <= mul_valid_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            sum_q        <= sum_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_p_q     <= resp_p_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_resp
            assign resp_p[gi] = resp_p_q[gi];
        end
    endgenerate

    assign req_ready  = req_ready_q;
    assign mul_valid  = mul_valid_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
`ifdef VEC_MUL_SEQ_ACCUM_EN
    assign resp_sum   = sum_q;
`else
    logic unused_sum;
    assign unused_sum = ^sum_q;
`endif
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Randomized and directed bench for vec_mul_sequencer against a request-level reference model.
module tb_vec_mul_sequencer;
    localparam int W   = 32;
    localparam int NE  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_vl;
    logic [W-1:0]  req_a [0:NE-1];
    logic [W-1:0]  req_b [0:NE-1];
    logic          mul_valid;
    logic [W-1:0]  mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic          resp_valid;
    logic          resp_ready;
    logic [2*W-1:0] resp_p [0:NE-1];
    logic          busy;
`ifdef VEC_MUL_SEQ_ACCUM_EN
    logic [2*W-1:0] resp_sum;
`endif

    logic [W-1:0]   stim_a [NE];
    logic [W-1:0]   stim_b [NE];
    logic [2*W-1:0] mpipe [LAT];
    int             n_pass = 0;
    int             n_total = 0;

    always #5 clk = ~clk;

    vec_mul_sequencer #(
        .WIDTH     (W),
        .NUM_ELEMS (NE),
        .MUL_LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vl     (req_vl),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_valid  (mul_valid),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .busy       (busy)
`ifdef VEC_MUL_SEQ_ACCUM_EN
        ,
        .resp_sum   (resp_sum)
`endif
    );

    // Environment multiplier: fixed LAT-cycle pipelined product.
    always @(posedge clk) begin
        mpipe[0] <= 64'(mul_a) * 64'(mul_b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_mul_valid", 64'(mul_valid), 64'd0);
        check_eq("rst_mul_a", 64'(mul_a), 64'd0);
        check_eq("rst_mul_b", 64'(mul_b), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < NE; i++) check_eq("rst_resp_p", resp_p[i], 64'd0);
`ifdef VEC_MUL_SEQ_ACCUM_EN
        check_eq("rst_resp_sum", resp_sum, 64'd0);
`endif
    endtask

    // One full request: accept, watch issues, wait for response, hold, release.
    task automatic run_req(input int vl, input int hold);
        int             vle, cyc, first, issues, exp_cyc;
        logic [63:0]    exp_p [NE];
        logic [63:0]    exp_sum;
        vle = (vl > NE) ? NE : vl;
        exp_sum = 64'd0;
        for (int i = 0; i < NE; i++) begin
            exp_p[i] = (i < vle) ? 64'(stim_a[i]) * 64'(stim_b[i]) : 64'd0;
            exp_sum += exp_p[i];
        end
        exp_cyc = (vle == 0) ? 1 : vle + LAT + 1;

        check_eq("idle_req_ready", 64'(req_ready), 64'd1);
        req_vl = 4'(vl);
        req_a = stim_a;
        req_b = stim_b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        first = 0;
        issues = 0;
        while (first == 0 && cyc < 64) begin
            if (mul_valid) begin
                if (issues < NE) begin
                    check_eq("mul_a", 64'(mul_a), 64'(stim_a[issues]));
                    check_eq("mul_b", 64'(mul_b), 64'(stim_b[issues]));
                end
                issues++;
            end else begin
                check_eq("mul_a_idle", 64'(mul_a | mul_b), 64'd0);
            end
            if (resp_valid) first = cyc;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check_eq("resp_cycle", 64'(first), 64'(exp_cyc));
        check_eq("issue_count", 64'(issues), 64'(vle));

        for (int h = 0; h < hold; h++) begin
            check_eq("hold_resp_valid", 64'(resp_valid), 64'd1);
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
            check_eq("hold_busy", 64'(busy), 64'd1);
            for (int i = 0; i < NE; i++) check_eq("hold_resp_p", resp_p[i], exp_p[i]);
            req_valid = (h == 1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;

        for (int i = 0; i < NE; i++) check_eq("resp_p", resp_p[i], exp_p[i]);
`ifdef VEC_MUL_SEQ_ACCUM_EN
        check_eq("resp_sum", resp_sum, exp_sum);
`endif
        check_eq("done_resp_valid", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq("post_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("post_req_ready", 64'(req_ready), 64'd1);
        check_eq("post_busy", 64'(busy), 64'd0);
        $display("req vl=%0d eff=%0d resp_cycle=%0d issues=%0d hold=%0d sum=0x%0h",
                 vl, vle, first, issues, hold, exp_sum);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        req_vl = '0;
        for (int i = 0; i < NE; i++) begin
            req_a[i] = '0;
            req_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NE; i++) begin stim_a[i] = W'(i + 1); stim_b[i] = 32'd3; end
        run_req(8, 0);
        for (int i = 0; i < NE; i++) begin stim_a[i] = W'(5 + 2 * i); stim_b[i] = 32'd2; end
        run_req(3, 0);
        run_req(0, 0);
        for (int i = 0; i < NE; i++) begin stim_a[i] = $urandom; stim_b[i] = $urandom; end
        run_req(12, 0);
        run_req(5, 5);

        // Reset in the middle of ISSUE, while element 4 is on the multiplier port.
        for (int i = 0; i < NE; i++) begin stim_a[i] = W'(100 + i); stim_b[i] = W'(7 + i); end
        req_vl = 4'd8;
        req_a = stim_a;
        req_b = stim_b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("pre_rst_mul_a", 64'(mul_a), 64'(stim_a[4]));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < NE; i++) begin stim_a[i] = W'(11 + i); stim_b[i] = W'(13 + i); end
        run_req(2, 0);

`ifdef VEC_MUL_SEQ_ACCUM_EN
        for (int i = 0; i < NE; i++) begin stim_a[i] = 32'hFFFF_FFFF; stim_b[i] = 32'hFFFF_FFFF; end
        run_req(8, 0);
`endif

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NE; i++) begin
                stim_a[i] = (t % 4 == 0) ? W'($urandom_range(0, 15)) : $urandom;
                stim_b[i] = $urandom;
            end
            run_req($urandom_range(0, 15), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vec_mul_sequencer.md
# vec_mul_sequencer

Sequencer that owns one shared element multiplier (the booth/Wallace datapath) and time-multiplexes it across the elements of a vector multiply request. It captures a full operand vector, issues one element pair per cycle to the multiplier, re-aligns products returning after a fixed pipeline latency, and presents the completed product vector through a valid/ready response handshake. It sits between the vector issue stage and the multiplier datapath in the VPU execute lane.

## Interface
- WIDTH, 32, element operand width in bits; products are 2*WIDTH.
- NUM_ELEMS, 8, maximum elements per request.
- MUL_LAT, 2, multiplier latency in cycles, 0 = combinational; legal range 0..8.
- IDX_W, $clog2(NUM_ELEMS), derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_vl  in  IDX_W+1  active element count.
- req_a  in  [WIDTH-1:0] [0:NUM_ELEMS-1]  multiplicand vector.
- req_b  in  [WIDTH-1:0] [0:NUM_ELEMS-1]  multiplier vector.
- mul_valid  out  1  operands on mul_a/mul_b are a real issue.
- mul_a  out  WIDTH  element operand A to the multiplier.
- mul_b  out  WIDTH  element operand B to the multiplier.
- mul_p  in  2*WIDTH  product, valid MUL_LAT cycles after its issue.
- resp_valid  out  1  product vector complete.
- resp_ready  in  1  consumer takes the response.
- resp_p  out  [2*WIDTH-1:0] [0:NUM_ELEMS-1]  product vector.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: req_ready=1. On req_valid, latch req_a, req_b, and vl_eff = min(req_vl, NUM_ELEMS), and clear resp_p to zero. Next state is ISSUE if vl_eff>0, else DONE.
- ISSUE: mul_valid=1. mul_a/mul_b = element idx, with idx counting 0..vl_eff-1, one per cycle. After issuing idx vl_eff-1, the next state is DRAIN if MUL_LAT>0, else DONE.
- DRAIN: mul_valid=0. Wait until the latency pipe holds no valid entries, then go to DONE.
- Product capture: a valid/index tag shifts MUL_LAT stages alongside the multiplier. When the tag emerges valid, write mul_p into resp_p[tag_idx]. With MUL_LAT=0, capture mul_p in the issue cycle.
- Tail elements (index >= vl_eff) read zero.
- DONE: resp_valid=1. resp_p is held stable until resp_ready=1, then the FSM returns to IDLE. req_ready=0 outside IDLE, and req_valid is ignored there.
- mul_a/mul_b are zero when mul_valid=0.

## Timing
- Reset values: req_ready=1, mul_valid=0, mul_a=mul_b=0, resp_valid=0, resp_p all zero, busy=0, latency pipe cleared, FSM in IDLE.
- Accept at edge E0. ISSUE occupies cycles 1..vl_eff. resp_valid first asserts in cycle vl_eff+MUL_LAT+1.
- vl_eff=0: resp_valid asserts in cycle 1 with all-zero resp_p.
- Response handshake completes at the edge where resp_valid and resp_ready are both 1. IDLE follows, so a new request is accepted no earlier than one cycle later (no same-cycle turnaround).
- req_vl > NUM_ELEMS is clamped to NUM_ELEMS.
- rst asserted in any state: next cycle is IDLE with reset values, and in-flight products are discarded.

## Configuration
- VEC_MUL_SEQ_ACCUM_EN defined:
  - Adds output port resp_sum (out, 2*WIDTH), the wrap-around modulo-2^(2*WIDTH) sum of captured products.
  - resp_sum is cleared on accept and valid with resp_valid.
  - Reset value is 0.
  - Used for dot-product ops.
- Not defined: the port and its accumulator logic are absent, and behaviour is otherwise identical.

## Structure
- Package vec_mul_seq_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - MUL_LAT_MAX=8;
  - the tag struct (valid bit plus index).
- Sub-module mul_lat_pipe is parameterised by depth MUL_LAT and index width. It is a tag shift register with a pass-through for depth 0, and exposes an any-valid flag for the DRAIN exit.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- WIDTH=32, MUL_LAT=2, vl=8, a[i]=i+1, b[i]=3 -> resp_p[i]=3*(i+1). mul_valid high for exactly 8 cycles. resp_valid first asserts in cycle 11.
- vl=3, a={5,7,9,...}, b={2,2,2,...} -> resp_p={10,14,18,0,0,0,0,0}, with tail zeroed.
- vl=0 -> resp_valid in cycle 1, all zeros, mul_valid never asserts. vl=12 with NUM_ELEMS=8 -> 8 issues.
- resp_ready held low for 5 cycles in DONE -> resp_valid and resp_p stable, req_ready=0. A req_valid pulse in this window is not accepted.
- rst pulsed during ISSUE at idx=4 -> next cycle all outputs at reset values. A following vl=2 request completes correctly with no stale captures.
- VEC_MUL_SEQ_ACCUM_EN, a[i]=0xFFFFFFFF, b[i]=0xFFFFFFFF, vl=8 -> resp_sum = 8*0xFFFFFFFE00000001 mod 2^64 = 0xFFFFFFF000000008.
